regfile_sb: RTL and testbench

Parametrised successor to the integer register file. It provides NRD registered read ports, one write-back port with same-cycle write-to-read bypass, and x0 hardwired to zero. It also holds a per-register pending scoreboard that is set at issue and cleared at write-back. It sits between decode/issue (read and issue ports) and write-back (write port), and gives decode the operand data plus a per-operand "not yet produced" flag for stall logic.

---
 rtl/regfile_sb.sv | 91 +++++++++
 tb/tb_regfile_sb.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Integer register file with NRD registered read ports, a write-back port that bypasses to same-cycle reads, and x0 hardwired to zero.
// Holds a per-register pending scoreboard that issue sets and write-back clears; read data and flags arrive one cycle after rd_en.
module regfile_sb #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NRD-1:0]       rd_en,
   input  logic [NRD*AW-1:0]    rd_addr,
   output logic [NRD*XLEN-1:0]  rd_data,
   output logic [NRD-1:0]       rd_pending,
   input  logic                 wr_enable,
   input  logic [AW-1:0]        wr_addr,
   input  logic [XLEN-1:0]      wr_data,
   input  logic                 issue_enable,
   input  logic [AW-1:0]        issue_addr,
   output logic [AW:0]          pending_count,
   output logic                 any_pending
);

   logic [XLEN-1:0]      mem_q [NREGS];
   logic [NREGS-1:0]     pend_q, pend_d;
   logic [AW:0]          cnt_q, cnt_d;
   logic [NRD*XLEN-1:0]  rdata_q, rdata_d;
   logic [NRD-1:0]       rpend_q, rpend_d;
   logic [AW-1:0]        ra;
   logic                 wr_vld, iss_vld, cnt_inc, cnt_dec;

   assign wr_vld  = wr_enable && (wr_addr != '0);
   assign iss_vld = issue_enable && (issue_addr != '0);

   // Issue is applied after write so a same-cycle producer on the same register keeps it pending.
   always_comb begin
      pend_d = pend_q;
      if (wr_vld)
         pend_d[wr_addr] = 1'b0;
      if (iss_vld)
         pend_d[issue_addr] = 1'b1;
      cnt_inc = iss_vld && !pend_q[issue_addr];
      cnt_dec = wr_vld && pend_q[wr_addr] && !(iss_vld && (issue_addr == wr_addr));
      cnt_d   = cnt_q + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
   end

   always_comb begin
      rdata_d = rdata_q;
      rpend_d = rpend_q;
      ra      = '0;
      for (int i = 0; i < NRD; i++) begin
         if (rd_en[i]) begin
            ra = rd_addr[i*AW +: AW];
            if (ra == '0) begin
               rdata_d[i*XLEN +: XLEN] = '0;
               rpend_d[i]              = 1'b0;
            end else if (wr_vld && (wr_addr == ra)) begin
               rdata_d[i*XLEN +: XLEN] = wr_data;
               rpend_d[i]              = 1'b0;
            end else begin
               rdata_d[i*XLEN +: XLEN] = mem_q[ra];
               rpend_d[i]              = pend_q[ra];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++)
            mem_q[i] <= '0;
         pend_q  <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         rpend_q <= '0;
      end else begin
         if (wr_vld)
            mem_q[wr_addr] <= wr_data;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         rpend_q <= rpend_d;
      end
   end

   assign rd_data       = rdata_q;
   assign rd_pending    = rpend_q;
   assign pending_count = cnt_q;
   assign any_pending   = (cnt_q != '0);

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios with literal expectations, then randomized traffic against a behavioural model.
module tb_regfile_sb;
   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int AW    = 5;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic [NRD-1:0]       rd_en;
   logic [NRD*AW-1:0]    rd_addr;
   logic [NRD*XLEN-1:0]  rd_data;
   logic [NRD-1:0]       rd_pending;
   logic                 wr_enable;
   logic [AW-1:0]        wr_addr;
   logic [XLEN-1:0]      wr_data;
   logic                 issue_enable;
   logic [AW-1:0]        issue_addr;
   logic [AW:0]          pending_count;
   logic                 any_pending;

   int total = 0;
   int bad   = 0;

   regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
      .clk(clk), .reset(reset),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
      .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
      .issue_enable(issue_enable), .issue_addr(issue_addr),
      .pending_count(pending_count), .any_pending(any_pending)
   );

   always #5 clk = ~clk;

   // Reference model: architectural state as plain arrays, read results latched per port.
   logic [XLEN-1:0]      m_mem [NREGS];
   bit                   m_pend [NREGS];
   logic [NRD*XLEN-1:0]  e_data;
   logic [NRD-1:0]       e_pend;
   logic [AW-1:0]        m_a;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
         end
         e_data = '0;
         e_pend = '0;
      end else begin
         for (int p = 0; p < NRD; p++) begin
            if (rd_en[p]) begin
               m_a = rd_addr[p*AW +: AW];
               if (m_a == 0) begin
                  e_data[p*XLEN +: XLEN] = '0;
                  e_pend[p] = 1'b0;
               end else if (wr_enable && wr_addr == m_a) begin
                  e_data[p*XLEN +: XLEN] = wr_data;
                  e_pend[p] = 1'b0;
               end else begin
                  e_data[p*XLEN +: XLEN] = m_mem[m_a];
                  e_pend[p] = m_pend[m_a];
               end
            end
         end
         if (wr_enable && wr_addr != 0) begin
            m_mem[wr_addr]  = wr_data;
            m_pend[wr_addr] = 1'b0;
         end
         if (issue_enable && issue_addr != 0)
            m_pend[issue_addr] = 1'b1;
      end
   end

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < NREGS; i++)
         n += int'(m_pend[i]);
      return n;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("cmp_rd_data", 64'(rd_data), 64'(e_data));
      chk("cmp_rd_pending", 64'(rd_pending), 64'(e_pend));
      chk("cmp_pending_count", 64'(pending_count), 64'(model_count()));
      chk("cmp_any_pending", 64'(any_pending), 64'(model_count() != 0));
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      rd_en        = '0;
      wr_enable    = 1'b0;
      issue_enable = 1'b0;
   endtask

   task automatic rd(input int p, input logic [AW-1:0] a);
      rd_en[p] = 1'b1;
      rd_addr[p*AW +: AW] = a;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      wr_enable = 1'b1;
      wr_addr   = a;
      wr_data   = d;
   endtask

   task automatic iss(input logic [AW-1:0] a);
      issue_enable = 1'b1;
      issue_addr   = a;
   endtask

   initial begin
      rd_en = '0; rd_addr = '0;
      wr_enable = 1'b0; wr_addr = '0; wr_data = '0;
      issue_enable = 1'b0; issue_addr = '0;
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Put some state in place, then reset between edges.
      wr(5'd3, 32'h11); cyc();
      rd(0, 5'd3); iss(5'd5); cyc();
      #2 reset = 1'b1;
      #1;
      chk("mid_reset_rd_data", 64'(rd_data), 64'd0);
      chk("mid_reset_rd_pending", 64'(rd_pending), 64'd0);
      chk("mid_reset_count", 64'(pending_count), 64'd0);
      #2 reset = 1'b0;

      rd(0, 5'd5); rd(1, 5'd0); cyc();
      chk("read_x5_x0", 64'(rd_data), 64'd0);
      chk("read_x5_x0_pend", 64'(rd_pending), 64'd0);

      wr(5'd3, 32'hDEADBEEF); cyc();
      rd(0, 5'd3); rd(1, 5'd3); cyc();
      chk("read_x3_both", 64'(rd_data), 64'hDEADBEEF_DEADBEEF);

      wr(5'd0, 32'h1234); cyc();
      rd(0, 5'd0); cyc();
      chk("read_x0_after_write", 64'(rd_data), 64'hDEADBEEF_00000000);

      rd(0, 5'd3); cyc();
      wr(5'd7, 32'hA5A5A5A5); rd(1, 5'd7); cyc();
      chk("bypass_port1_hold_port0", 64'(rd_data), 64'hA5A5A5A5_DEADBEEF);

      iss(5'd4); cyc();
      chk("issue_x4_count", 64'(pending_count), 64'd1);
      rd(0, 5'd4); cyc();
      chk("read_x4_pending", 64'(rd_pending), 64'b01);
      wr(5'd4, 32'd9); rd(0, 5'd4); cyc();
      chk("wb_x4_bypass_data", 64'(rd_data[31:0]), 64'd9);
      chk("wb_x4_bypass_pend", 64'(rd_pending), 64'd0);
      chk("wb_x4_count", 64'(pending_count), 64'd0);

      iss(5'd6); cyc();
      wr(5'd6, 32'h66); iss(5'd6); cyc();
      chk("issue_wr_x6_count", 64'(pending_count), 64'd1);
      rd(0, 5'd6); cyc();
      chk("issue_wr_x6_data", 64'(rd_data[31:0]), 64'h66);
      chk("issue_wr_x6_pend", 64'(rd_pending), 64'b01);
      iss(5'd0); cyc();
      chk("issue_x0_count", 64'(pending_count), 64'd1);

      wr(5'd6, 32'd0); cyc();
      chk("clear_x6_count", 64'(pending_count), 64'd0);
      iss(5'd2); cyc();
      iss(5'd9); cyc();
      chk("issue_x2_x9_count", 64'(pending_count), 64'd2);
      chk("issue_x2_x9_any", 64'(any_pending), 64'd1);

      iss(5'd4); cyc();
      iss(5'd8); cyc();
      chk("four_pending_count", 64'(pending_count), 64'd4);
      wr(5'd11, 32'h77);
      #2 reset = 1'b1;
      #1;
      chk("reset_inflight_count", 64'(pending_count), 64'd0);
      chk("reset_inflight_any", 64'(any_pending), 64'd0);
      wr_enable = 1'b0;
      #2 reset = 1'b0;
      rd(0, 5'd11); rd(1, 5'd8); cyc();
      chk("reset_inflight_data", 64'(rd_data), 64'd0);
      chk("reset_inflight_pend", 64'(rd_pending), 64'd0);

      // Randomized traffic; small address window half the time to force collisions.
      for (int n = 0; n < 3000; n++) begin
         for (int p = 0; p < NRD; p++) begin
            rd_en[p] = ($urandom_range(0, 3) != 0);
            rd_addr[p*AW +: AW] = AW'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, NREGS-1));
         end
         wr_enable    = ($urandom_range(0, 1) != 0);
         wr_addr      = AW'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, NREGS-1));
         wr_data      = $urandom;
         issue_enable = ($urandom_range(0, 2) != 0);
         issue_addr   = AW'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, NREGS-1));
         if ($urandom_range(0, 499) == 0) begin
            #2 reset = 1'b1;
            #2 reset = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      rd_en = '0; wr_enable = 1'b0; issue_enable = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
